argmax_classifier: RTL and testbench

Final decision stage of the emotion-recognition pipeline. It sits directly downstream of the global average pooling stage and consumes its 7-channel vector of IEEE-754 single-precision class scores. For each vector it scans the channels serially, one per cycle, and emits the index of the largest score (the predicted emotion class) together with that score. A one-deep pending buffer absorbs a second vector that arrives while a scan is in progress.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/argmax_classifier_if.sv | 23 ++
 rtl/fp_max_cmp.sv | 25 ++
 rtl/argmax_classifier.sv | 111 +++++++++++
 tb/tb_argmax_classifier.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN decision stages: score width, float order key, FSM states.
package cnn_pkg;

  localparam int unsigned DATA_WIDHT = 32;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  // Map an IEEE-754 single to an unsigned key whose integer order matches the
  // float order (+0 above -0, NaNs ordered purely by bit pattern).
  function automatic logic [DATA_WIDHT-1:0] fp_to_key(input logic [DATA_WIDHT-1:0] x);
    fp_to_key = x[DATA_WIDHT-1] ? ~x : (x ^ {1'b1, {(DATA_WIDHT-1){1'b0}}});
  endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Score-vector in / class-result out bundle for the argmax classifier.
interface argmax_classifier_if #(
  parameter int unsigned DATA_WIDHT = 32,
  parameter int unsigned CHANNEL_IN = 7,
  parameter int unsigned CLASS_W    = $clog2(CHANNEL_IN)
);
  logic [DATA_WIDHT*CHANNEL_IN-1:0] Data_In;
  logic                             Valid_In;
  logic [CLASS_W-1:0]               Class_Out;
  logic [DATA_WIDHT-1:0]            Score_Out;
  logic                             Valid_Out;
  logic                             Overflow;

  modport master (
    output Data_In, Valid_In,
    input  Class_Out, Score_Out, Valid_Out, Overflow
  );

  modport slave (
    input  Data_In, Valid_In,
    output Class_Out, Score_Out, Valid_Out, Overflow
  );
endinterface

// File: rtl/fp_max_cmp.sv
// Combinational float max: candidate replaces best only when strictly greater.
module fp_max_cmp
  import cnn_pkg::*;
#(
  parameter int unsigned CLASS_W = 3
) (
  input  logic [DATA_WIDHT-1:0] cand_score,
  input  logic [CLASS_W-1:0]    cand_idx,
  input  logic [DATA_WIDHT-1:0] best_score,
  input  logic [CLASS_W-1:0]    best_idx,
  output logic [DATA_WIDHT-1:0] new_score,
  output logic [CLASS_W-1:0]    new_idx
);

  // Strict compare keeps the earlier (lower) index on ties.
  always_comb begin
    new_score = best_score;
    new_idx   = best_idx;
    if (fp_to_key(cand_score) > fp_to_key(best_score)) begin
      new_score = cand_score;
      new_idx   = cand_idx;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Serial argmax over a vector of float class scores, one channel per cycle,
// with a one-deep pending buffer for a vector arriving mid-scan.
module argmax_classifier
  import cnn_pkg::*;
#(
  parameter int unsigned CHANNEL_IN = 7,
  parameter int unsigned CLASS_W    = $clog2(CHANNEL_IN)
) (
  input logic                clk,
  input logic                rst,
  argmax_classifier_if.slave bus
);

  localparam int unsigned VW = DATA_WIDHT * CHANNEL_IN;

  state_t                state;
  logic [VW-1:0]         work;
  logic [VW-1:0]         pend;
  logic                  pend_full;
  logic [DATA_WIDHT-1:0] best;
  logic [CLASS_W-1:0]    best_idx;
  logic [CLASS_W-1:0]    idx;

  logic [DATA_WIDHT-1:0] ch [CHANNEL_IN];
  logic [DATA_WIDHT-1:0] nb;
  logic [CLASS_W-1:0]    nb_idx;
  logic                  last;

  // Split the working buffer into per-channel scores for the idx mux.
  always_comb begin
    for (int unsigned i = 0; i < CHANNEL_IN; i++) begin
      ch[i] = work[DATA_WIDHT*i +: DATA_WIDHT];
    end
  end

  assign last = (idx == CLASS_W'(CHANNEL_IN - 1));

  fp_max_cmp #(.CLASS_W(CLASS_W)) u_cmp (
    .cand_score (ch[idx]),
    .cand_idx   (idx),
    .best_score (best),
    .best_idx   (best_idx),
    .new_score  (nb),
    .new_idx    (nb_idx)
  );

  // Scan FSM, buffers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      work          <= '0;
      pend          <= '0;
      pend_full     <= 1'b0;
      best          <= '0;
      best_idx      <= '0;
      idx           <= '0;
      bus.Class_Out <= '0;
      bus.Score_Out <= '0;
      bus.Valid_Out <= 1'b0;
      bus.Overflow  <= 1'b0;
    end else begin
      bus.Valid_Out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Valid_In) begin
            work     <= bus.Data_In;
            best     <= bus.Data_In[DATA_WIDHT-1:0];
            best_idx <= '0;
            idx      <= CLASS_W'(1);
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (last) begin
            bus.Class_Out <= nb_idx;
            bus.Score_Out <= nb;
            bus.Valid_Out <= 1'b1;
            best_idx      <= '0;
            idx           <= CLASS_W'(1);
            // Pending has priority; a coincident Valid_In refills pending so nothing drops.
            if (pend_full) begin
              work <= pend;
              best <= pend[DATA_WIDHT-1:0];
              if (bus.Valid_In) pend <= bus.Data_In;
              else              pend_full <= 1'b0;
            end else if (bus.Valid_In) begin
              work <= bus.Data_In;
              best <= bus.Data_In[DATA_WIDHT-1:0];
            end else begin
              state <= IDLE;
            end
          end else begin
            best     <= nb;
            best_idx <= nb_idx;
            idx      <= idx + CLASS_W'(1);
            if (bus.Valid_In) begin
              if (!pend_full) begin
                pend      <= bus.Data_In;
                pend_full <= 1'b1;
              end else begin
                bus.Overflow <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: vector table, timing corner cases, random replay.
module tb_argmax_classifier;

  localparam int unsigned DW = 32;
  localparam int unsigned CH = 7;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [CW-1:0] cls;
    logic [DW-1:0] score;
  } exp_t;

  typedef struct {
    logic [DW*CH-1:0] data;
    logic [CW-1:0]    cls;
    logic [DW-1:0]    score;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   vo_count = 0;
  int   last_vo = 0;
  int   prev_vo = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  argmax_classifier_if #(.DATA_WIDHT(DW), .CHANNEL_IN(CH), .CLASS_W(CW)) bus ();

  argmax_classifier #(.CHANNEL_IN(CH), .CLASS_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] key_of(input logic [DW-1:0] x);
    if (x[DW-1]) return ~x;
    return {1'b1, x[DW-2:0]};
  endfunction

  function automatic exp_t model(input logic [DW*CH-1:0] d);
    exp_t r;
    logic [DW-1:0] s;
    r.cls   = '0;
    r.score = d[DW-1:0];
    for (int i = 1; i < int'(CH); i++) begin
      s = d[DW*i +: DW];
      if (key_of(s) > key_of(r.score)) begin
        r.cls   = CW'(i);
        r.score = s;
      end
    end
    return r;
  endfunction

  function automatic logic [DW*CH-1:0] pack7(input logic [DW-1:0] c0, c1, c2, c3, c4, c5, c6);
    return {c6, c5, c4, c3, c2, c1, c0};
  endfunction

  // Output monitor: every Valid_Out pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.Valid_Out) begin
        vo_count++;
        prev_vo = last_vo;
        last_vo = cyc;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got class %0d score 0x%08h, expected no output", bus.Class_Out, bus.Score_Out);
        end else begin
          e = sbq.pop_front();
          check("class", DW'(bus.Class_Out), DW'(e.cls));
          check("score", bus.Score_Out, e.score);
        end
      end
    end
  end

  task automatic send(input logic [DW*CH-1:0] d, output int cap);
    @(negedge clk);
    bus.Data_In  = d;
    bus.Valid_In = 1'b1;
    cap = cyc + 1;
    @(negedge clk);
    bus.Valid_In = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d results outstanding, expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  vec_t tbl[$];
  int   cap;
  int   cap_a;
  int   vo_before;
  logic [DW*CH-1:0] va;
  logic [DW*CH-1:0] vb;

  initial begin
    bus.Data_In  = '0;
    bus.Valid_In = 1'b0;

    tbl.push_back('{pack7(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000,
                          32'h00000000, 32'hC0000000, 32'h3F000000), 3'd3, 32'h40400000});
    tbl.push_back('{pack7(32'hBF800000, 32'hC0000000, 32'hC0800000, 32'hC0800000,
                          32'hC0800000, 32'hBF000000, 32'hC0800000), 3'd5, 32'hBF000000});
    tbl.push_back('{pack7(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                          32'h40000000, 32'h40000000, 32'h40000000), 3'd0, 32'h40000000});
    tbl.push_back('{pack7(32'hBF800000, 32'hBF800000, 32'h80000000, 32'hBF800000,
                          32'h00000000, 32'hBF800000, 32'hBF800000), 3'd4, 32'h00000000});
    tbl.push_back('{pack7(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                          32'h3F800000, 32'h3F800000, 32'h7F800000), 3'd6, 32'h7F800000});
    tbl.push_back('{pack7(32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h7F800000,
                          32'h3F800000, 32'h3F800000, 32'h3F800000), 3'd1, 32'h7FC00000});
    tbl.push_back('{pack7(32'hFFC00000, 32'hFF800000, 32'hFF800000, 32'hFF800000,
                          32'hFF800000, 32'hFF800000, 32'hFF800000), 3'd1, 32'hFF800000});

    // Reset state
    #1;
    check("rst_class", DW'(bus.Class_Out), '0);
    check("rst_score", bus.Score_Out, '0);
    check("rst_valid", DW'(bus.Valid_Out), '0);
    check("rst_overflow", DW'(bus.Overflow), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table vectors, one at a time, with latency check
    foreach (tbl[i]) begin
      sbq.push_back('{tbl[i].cls, tbl[i].score});
      send(tbl[i].data, cap);
      drain("table_drain");
      check("table_latency", DW'(last_vo - cap), DW'(6));
    end

    // Valid_In on the last-compare edge with pending empty: direct capture
    va = tbl[0].data;
    vb = tbl[1].data;
    sbq.push_back('{tbl[0].cls, tbl[0].score});
    sbq.push_back('{tbl[1].cls, tbl[1].score});
    send(va, cap);
    repeat (4) @(negedge clk);
    send(vb, cap);
    drain("direct_drain");
    check("direct_spacing", DW'(last_vo - prev_vo), DW'(6));
    check("direct_overflow", DW'(bus.Overflow), '0);

    // A, B two cycles later (pending), C three after B (dropped)
    sbq.push_back('{tbl[2].cls, tbl[2].score});
    sbq.push_back('{tbl[3].cls, tbl[3].score});
    send(tbl[2].data, cap_a);
    send(tbl[3].data, cap);
    @(negedge clk);
    send(tbl[4].data, cap);
    check("ovf_set", DW'(bus.Overflow), DW'(1));
    drain("ovf_drain");
    check("ovf_b_no_bubble", DW'(last_vo - prev_vo), DW'(6));
    check("ovf_a_latency", DW'(prev_vo - cap_a), DW'(6));
    sbq.push_back('{tbl[5].cls, tbl[5].score});
    send(tbl[5].data, cap);
    drain("ovf_after_drain");
    check("ovf_sticky", DW'(bus.Overflow), DW'(1));

    // Reset mid-scan at idx=3
    check("pre_rst_class", DW'(bus.Class_Out), DW'(1));
    vo_before = vo_count;
    send(tbl[0].data, cap);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_class", DW'(bus.Class_Out), '0);
    check("midrst_score", bus.Score_Out, '0);
    check("midrst_overflow", DW'(bus.Overflow), '0);
    check("midrst_valid", DW'(bus.Valid_Out), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_output", DW'(vo_count - vo_before), '0);
    sbq.push_back('{tbl[1].cls, tbl[1].score});
    send(tbl[1].data, cap);
    drain("post_rst_drain");
    check("post_rst_latency", DW'(last_vo - cap), DW'(6));

    // Random replay of pooled score vectors against the bench model
    for (int v = 0; v < 40; v++) begin
      logic [DW*CH-1:0] d;
      logic [DW-1:0] pool [5];
      int gap;
      pool[0] = 32'h3F800000; pool[1] = 32'hBF800000; pool[2] = 32'h00000000;
      pool[3] = 32'h80000000; pool[4] = 32'h40000000;
      for (int c = 0; c < int'(CH); c++) begin
        if ($urandom_range(0, 1) == 0) d[DW*c +: DW] = pool[$urandom_range(0, 4)];
        else                           d[DW*c +: DW] = $urandom;
      end
      sbq.push_back(model(d));
      send(d, cap);
      gap = $urandom_range(6, 9);
      repeat (gap - 2) @(negedge clk);
    end
    drain("replay_drain");
    check("replay_overflow", DW'(bus.Overflow), '0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
